booth_mult_ctrl: RTL and testbench
==================================

Name: booth_mult_ctrl

Overview:
- FSM controller that sequences the 4-bit signed (radix-2 Booth) multiplier datapath.
- Accepts a start request from the host and drives the datapath load, add/subtract, mux and shift strobes.
- Inspects the multiplier LSB pair {Q0, Q-1} each iteration and signals completion with a busy/done handshake.
- Uses its own iteration counter; it does not rely on the datapath's free-running counter.

Parameters:
- DATA_WIDTH, 4: multiplier/iteration count.
- CNT_WIDTH, 3: iteration counter width; must hold DATA_WIDTH.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  start request; sampled in IDLE only.
- i_q0  input  1  multiplier LSB (datapath Q).
- i_q_m1  input  1  appended bit Q-1 (datapath Q_n).
- o_load_acc  output  1  accumulator load strobe.
- o_load_q  output  1  multiplier register load/shift strobe.
- o_load_m  output  1  multiplicand register load strobe.
- o_clr_q  output  1  clears Q-1 during initial load.
- o_sel_mux  output  1  0 = zero into ACC, 1 = adder/subtractor result into ACC.
- o_add_sub  output  1  0 = add, 1 = subtract.
- o_cin  output  1  carry-in; equals o_add_sub in subtract (two's complement).
- o_shift  output  1  arithmetic right shift of {ACC, Q, Q-1}.
- o_busy  output  1  operation in progress.
- o_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state = IDLE, counter = 0, every output 0 on the edge after i_rst is high. Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, LOAD, CHECK, SHIFT, DONE. State is registered; strobes are combinational from state plus {i_q0, i_q_m1}.
- IDLE: all strobes 0, o_busy = 0. If i_start = 1, go to LOAD.
- LOAD (1 cycle):
  - o_load_m = 1, o_load_q = 1, o_clr_q = 1.
  - o_load_acc = 1 with o_sel_mux = 0, which clears ACC.
  - counter <= DATA_WIDTH. Next state: CHECK.
- CHECK (1 cycle), by {i_q0, i_q_m1}:
  - 2'b01: ADD. o_load_acc = 1, o_sel_mux = 1, o_add_sub = 0, o_cin = 0.
  - 2'b10: SUB. o_load_acc = 1, o_sel_mux = 1, o_add_sub = 1, o_cin = 1.
  - 2'b00 or 2'b11: no strobes.
  - Next state: SHIFT.
- SHIFT (1 cycle):
  - o_shift = 1 and o_load_q = 1; the datapath shifts ACC LSB into Q.
  - counter decrements.
  - If counter == 1 before the decrement, go to DONE; otherwise go to CHECK.
- DONE (1 cycle): o_done = 1, o_busy = 1. Next state: IDLE.
- o_busy is 1 in LOAD, CHECK, SHIFT and DONE.
- Latency: start sampled at edge 0; LOAD in cycle 1; CHECK/SHIFT pairs in cycles 2..9; o_done high in cycle 10. Next start is accepted in cycle 11 (IDLE).
- i_start while busy (including the DONE cycle) is ignored; it is not queued.
- i_start held high continuously produces back-to-back operations, 11 cycles each.
- Mutual exclusion: o_shift is never asserted with o_sel_mux = 1. o_load_m is asserted only in LOAD.
- Counter never wraps: it reaches 0 only on the transition to DONE.
- i_q0 and i_q_m1 are sampled only in CHECK and are don't-care elsewhere.

Decomposition:
- Shared package: the state enum (IDLE/LOAD/CHECK/SHIFT/DONE encodings, 3 bits), the Booth pair constants (PAIR_ADD = 2'b01, PAIR_SUB = 2'b10), and the DATA_WIDTH/CNT_WIDTH defaults.
- One natural sub-module: booth_iter_counter (load, decrement, last-flag).
- The FSM and output decode stay in the top module.

Test Plan:
- Reset/idle: i_rst high for 3 cycles with i_start = 1 -> all outputs 0 and no LOAD. Release reset -> LOAD in the cycle after i_start is sampled.
- Multiplier -2 (1110), M = 3, datapath attached -> CHECK sequence is none/SUB/none/none. o_done pulses in cycle 10. Product {ACC, Q[4:1]} = 8'hFA (-6).
- Multiplier 5 (0101), M = -3 -> CHECK sequence is SUB/ADD/SUB/ADD, with o_cin = 1 exactly on the SUB cycles. Product = 8'hF1 (-15).
- Multiplier -8 (1000), M = -8 -> CHECK sequence is none/none/none/SUB. Product = 8'h40 (64).
- i_start pulsed in cycles 3, 7 and 10 of an active operation -> ignored; exactly one o_done. i_start held high -> o_done in cycles 10, 21 and 32.
- i_rst asserted in cycle 5 (mid-SHIFT) -> next cycle state is IDLE and all strobes are 0; no o_done. A fresh start then completes normally with the correct product.

Source files
------------

// File: rtl/booth_mult_ctrl_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller:
// FSM state encoding, Booth pair decode and the strobe bundle.
package booth_mult_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_CNT_WIDTH  = 3;

    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_e;

    typedef struct packed {
        logic load_acc;
        logic load_q;
        logic load_m;
        logic clr_q;
        logic sel_mux;
        logic add_sub;
        logic cin;
        logic shift;
        logic busy;
        logic done;
    } strobes_t;

    // Pairs 00 and 11 sit inside a run of equal bits, so nothing is added.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        op = OP_NONE;
        if (pair == PAIR_ADD) begin
            op = OP_ADD;
        end else if (pair == PAIR_SUB) begin
            op = OP_SUB;
        end
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Host/datapath side of the Booth controller: start request, multiplier
// LSB pair and every datapath strobe.
interface booth_mult_ctrl_if;

    logic i_start;
    logic i_q0;
    logic i_q_m1;
    logic o_load_acc;
    logic o_load_q;
    logic o_load_m;
    logic o_clr_q;
    logic o_sel_mux;
    logic o_add_sub;
    logic o_cin;
    logic o_shift;
    logic o_busy;
    logic o_done;

    modport slave (
        input  i_start,
        input  i_q0,
        input  i_q_m1,
        output o_load_acc,
        output o_load_q,
        output o_load_m,
        output o_clr_q,
        output o_sel_mux,
        output o_add_sub,
        output o_cin,
        output o_shift,
        output o_busy,
        output o_done
    );

    modport master (
        output i_start,
        output i_q0,
        output i_q_m1,
        input  o_load_acc,
        input  o_load_q,
        input  o_load_m,
        input  o_clr_q,
        input  o_sel_mux,
        input  o_add_sub,
        input  o_cin,
        input  o_shift,
        input  o_busy,
        input  o_done
    );

endinterface

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth controller: loaded with the operand width,
// decremented once per shift, flags the final iteration.
module booth_iter_counter
    import booth_mult_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int LOAD_VALUE = DEF_DATA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Saturating at zero keeps the count from wrapping if dec ever arrives late.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_WIDTH'(LOAD_VALUE);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiplier controller: LOAD, then CHECK/SHIFT per multiplier
// bit, then a one-cycle DONE pulse. Strobes decode from state and {Q0, Q-1}.
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    booth_mult_ctrl_if.slave   bus
);

    state_e   state_q;
    state_e   state_d;
    strobes_t str;
    logic     cnt_last;

    booth_iter_counter #(
        .CNT_WIDTH  (CNT_WIDTH),
        .LOAD_VALUE (DATA_WIDTH)
    ) u_iter_counter (
        .clk  (i_clk),
        .rst  (i_rst),
        .load (state_q == ST_LOAD),
        .dec  (state_q == ST_SHIFT),
        .last (cnt_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start is only looked at in IDLE, so requests during an operation are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.i_start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_CHECK;
            ST_CHECK: state_d = ST_SHIFT;
            ST_SHIFT: state_d = cnt_last ? ST_DONE : ST_CHECK;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        str = '0;
        case (state_q)
            ST_LOAD: begin
                str.load_m   = 1'b1;
                str.load_q   = 1'b1;
                str.clr_q    = 1'b1;
                str.load_acc = 1'b1;
                str.busy     = 1'b1;
            end
            ST_CHECK: begin
                str.busy = 1'b1;
                case (booth_decode({bus.i_q0, bus.i_q_m1}))
                    OP_ADD: begin
                        str.load_acc = 1'b1;
                        str.sel_mux  = 1'b1;
                    end
                    // Subtract as add of ~M with carry-in 1.
                    OP_SUB: begin
                        str.load_acc = 1'b1;
                        str.sel_mux  = 1'b1;
                        str.add_sub  = 1'b1;
                        str.cin      = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_SHIFT: begin
                str.shift  = 1'b1;
                str.load_q = 1'b1;
                str.busy   = 1'b1;
            end
            ST_DONE: begin
                str.done = 1'b1;
                str.busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.o_load_acc = str.load_acc;
    assign bus.o_load_q   = str.load_q;
    assign bus.o_load_m   = str.load_m;
    assign bus.o_clr_q    = str.clr_q;
    assign bus.o_sel_mux  = str.sel_mux;
    assign bus.o_add_sub  = str.add_sub;
    assign bus.o_cin      = str.cin;
    assign bus.o_shift    = str.shift;
    assign bus.o_busy     = str.busy;
    assign bus.o_done     = str.done;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl with a behavioural Booth datapath attached
// so strobe sequences and final products can both be checked.
module tb_booth_mult_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    booth_mult_ctrl_if bus ();

    booth_mult_ctrl #(
        .DATA_WIDTH (4),
        .CNT_WIDTH  (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] mult_in  = 4'd0;
    logic [3:0] mcand_in = 4'd0;
    logic [4:0] acc      = 5'd0;
    logic [3:0] q        = 4'd0;
    logic       qm1      = 1'b0;
    logic [4:0] m        = 5'd0;

    assign bus.i_q0   = q[0];
    assign bus.i_q_m1 = qm1;

    // One guard bit on ACC so -8 x -8 does not overflow the accumulator.
    always @(posedge clk) begin
        if (bus.o_load_m) m <= {mcand_in[3], mcand_in};
        if (bus.o_load_acc)
            acc <= bus.o_sel_mux ? (acc + (bus.o_add_sub ? ~m : m) + {4'd0, bus.o_cin}) : 5'd0;
        if (bus.o_load_q && bus.o_clr_q) begin
            q   <= mult_in;
            qm1 <= 1'b0;
        end else if (bus.o_load_q && bus.o_shift) begin
            {acc, q, qm1} <= {acc[4], acc, q};
        end
    end

    wire [9:0] obs = {bus.o_load_acc, bus.o_load_q, bus.o_load_m, bus.o_clr_q, bus.o_sel_mux,
                      bus.o_add_sub, bus.o_cin, bus.o_shift, bus.o_busy, bus.o_done};
    wire [7:0] prod = {acc[3:0], q};

    // Expected strobes for cycle c after start; ops holds the CHECK decisions, first in bits [1:0].
    function automatic logic [9:0] exp_vec(input int c, input logic [7:0] ops);
        logic [1:0] op;
        if (c == 1) return 10'b1111000010;
        if (c >= 2 && c <= 9) begin
            if (c % 2 == 1) return 10'b0100000110;
            op = ops[(c-2) +: 2];
            case (op)
                2'd1:    return 10'b1000100010;
                2'd2:    return 10'b1000111010;
                default: return 10'b0000000010;
            endcase
        end
        if (c == 10) return 10'b0000000011;
        return 10'b0000000000;
    endfunction

    task automatic run_op(input string name, input logic [3:0] mult, input logic [3:0] mcand,
                          input logic [7:0] ops, input logic [7:0] product, input logic [11:0] start_mask);
        int dones;
        dones = 0;
        mult_in     = mult;
        mcand_in    = mcand;
        bus.i_start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(c, ops)) begin
                errors++;
                $display("[TB] FAIL %s cycle%0d strobes: got %b expected %b", name, c, obs, exp_vec(c, ops));
            end
            checks++;
            if (bus.o_shift === 1'b1 && bus.o_sel_mux === 1'b1) begin
                errors++;
                $display("[TB] FAIL %s cycle%0d shift_vs_mux: got shift=1 sel_mux=1 expected exclusive", name, c);
            end
            if (bus.o_done === 1'b1) dones++;
            if (c == 10) begin
                checks++;
                if (prod !== product) begin
                    errors++;
                    $display("[TB] FAIL %s product: got %h expected %h", name, prod, product);
                end
            end
            bus.i_start = start_mask[c];
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL %s done_count: got %0d expected 1", name, dones);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.i_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 10'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold%0d: got %b expected %b", i, obs, 10'd0);
            end
        end
        rst = 1'b0;
        run_op("reset_release", 4'b1110, 4'b0011, 8'h08, 8'hFA, 12'h000);
    endtask

    task automatic test_mult_neg2();
        run_op("mult_neg2", 4'b1110, 4'b0011, 8'h08, 8'hFA, 12'h000);
    endtask

    task automatic test_mult_5();
        run_op("mult_5", 4'b0101, 4'b1101, 8'h66, 8'hF1, 12'h000);
    endtask

    task automatic test_mult_neg8();
        run_op("mult_neg8", 4'b1000, 4'b1000, 8'h80, 8'h40, 12'h000);
    endtask

    task automatic test_ignore_start();
        run_op("ignore_start", 4'b0101, 4'b1101, 8'h66, 8'hF1, 12'h488);
        @(negedge clk);
        checks++;
        if (obs !== 10'd0) begin
            errors++;
            $display("[TB] FAIL ignore_start idle_after: got %b expected %b", obs, 10'd0);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_1", 4'b1110, 4'b0011, 8'h08, 8'hFA, 12'hFFE);
        run_op("b2b_2", 4'b0101, 4'b1101, 8'h66, 8'hF1, 12'hFFE);
        run_op("b2b_3", 4'b1000, 4'b1000, 8'h80, 8'h40, 12'h7FE);
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset_mid();
        mult_in     = 4'b1110;
        mcand_in    = 4'b0011;
        bus.i_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.i_start = 1'b0;
        end
        checks++;
        if (obs !== 10'b0100000110) begin
            errors++;
            $display("[TB] FAIL reset_mid shift_cycle: got %b expected %b", obs, 10'b0100000110);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid abort: got %b expected %b", obs, 10'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 10'd0) begin
                errors++;
                $display("[TB] FAIL reset_mid quiet%0d: got %b expected %b", i, obs, 10'd0);
            end
        end
        run_op("after_reset", 4'b1000, 4'b1000, 8'h80, 8'h40, 12'h000);
    endtask

    initial begin
        $display("[TB] booth_mult_ctrl directed tests");
        test_reset();
        test_mult_neg2();
        test_mult_5();
        test_mult_neg8();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
